// File: rtl/axi4_pkg.sv
// rtl/axi4_pkg.sv - shared response codes and FSM state types for the AXI4 SRAM slave
package axi4_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_ARB, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_ARB, R_DATA} rstate_t;

endpackage

// File: rtl/sram_1rw_be.sv
// rtl/sram_1rw_be.sv - single-port synchronous RAM, byte-enabled write, registered read
module sram_1rw_be #(
    parameter int DW = 64,
    parameter int AW = 10
) (
    input  logic            clk,
    input  logic            en,
    input  logic            we,
    input  logic [DW/8-1:0] be,
    input  logic [AW-1:0]   addr,
    input  logic [DW-1:0]   wdata,
    output logic [DW-1:0]   rdata
);

    logic [DW-1:0] mem [2**AW];

    // rdata only moves on a read, so it stays stable across intervening writes
    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int i = 0; i < DW/8; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end else if (en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/axi4_sram_slave.sv
// rtl/axi4_sram_slave.sv - single-beat AXI4 slave over a shared single-port SRAM
module axi4_sram_slave
    import axi4_pkg::*;
#(
    parameter int C_AXI_DATA_WIDTH = 64,
    parameter int C_AXI_ADDR_WIDTH = 26,
    parameter int C_AXI_ID_WIDTH   = 1,
    parameter int MEM_AW           = 10
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic                          i_axi_awvalid,
    output logic                          o_axi_awready,
    input  logic [C_AXI_ID_WIDTH-1:0]     i_axi_awid,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   i_axi_awaddr,
    input  logic [7:0]                    i_axi_awlen,
    input  logic [2:0]                    i_axi_awsize,
    input  logic                          i_axi_wvalid,
    output logic                          o_axi_wready,
    input  logic [C_AXI_DATA_WIDTH-1:0]   i_axi_wdata,
    input  logic [C_AXI_DATA_WIDTH/8-1:0] i_axi_wstrb,
    input  logic                          i_axi_wlast,
    output logic                          o_axi_bvalid,
    input  logic                          i_axi_bready,
    output logic [C_AXI_ID_WIDTH-1:0]     o_axi_bid,
    output logic [1:0]                    o_axi_bresp,
    input  logic                          i_axi_arvalid,
    output logic                          o_axi_arready,
    input  logic [C_AXI_ID_WIDTH-1:0]     i_axi_arid,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   i_axi_araddr,
    input  logic [7:0]                    i_axi_arlen,
    output logic                          o_axi_rvalid,
    input  logic                          i_axi_rready,
    output logic [C_AXI_ID_WIDTH-1:0]     o_axi_rid,
    output logic [C_AXI_DATA_WIDTH-1:0]   o_axi_rdata,
    output logic [1:0]                    o_axi_rresp,
    output logic                          o_axi_rlast
);

    localparam int NB = C_AXI_DATA_WIDTH / 8;

    wstate_t                 wstate;
    rstate_t                 rstate;
    logic                    aw_held, w_held, w_first_held;
    logic [MEM_AW-1:0]       w_word, r_word;
    logic                    w_err, r_err, r_use_ram, prio_w;
    logic [C_AXI_DATA_WIDTH-1:0] w_data, ram_q;
    logic [NB-1:0]           w_strb;
    logic                    w_req, r_req, w_gnt, r_gnt;
    logic                    ram_en, ram_we;
    logic [MEM_AW-1:0]       ram_addr;
    logic                    aw_hs, w_hs, w_last_hs, ar_hs;
    logic                    unused_ok;

    assign unused_ok = ^{i_axi_awsize, i_axi_awaddr[2:0], i_axi_araddr[2:0]};

    function automatic logic out_of_range(input logic [C_AXI_ADDR_WIDTH-1:0] a);
        return (a >> (MEM_AW + 3)) != '0;
    endfunction

    // Round-robin only on contention; a lone requester wins without moving the priority
    assign w_req = (wstate == W_ARB);
    assign r_req = (rstate == R_ARB);
    assign w_gnt = w_req && (!r_req || prio_w);
    assign r_gnt = r_req && (!w_req || !prio_w);

    assign ram_en   = (w_gnt && !w_err) || (r_gnt && !r_err);
    assign ram_we   = w_gnt;
    assign ram_addr = w_gnt ? w_word : r_word;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) prio_w <= 1'b1;
        else if (w_req && r_req) prio_w <= !w_gnt;
    end

    assign aw_hs     = i_axi_awvalid && o_axi_awready;
    assign w_hs      = i_axi_wvalid && o_axi_wready;
    assign w_last_hs = w_hs && i_axi_wlast;
    assign ar_hs     = i_axi_arvalid && o_axi_arready;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wstate        <= W_IDLE;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            w_first_held  <= 1'b0;
            w_word        <= '0;
            w_err         <= 1'b0;
            w_data        <= '0;
            w_strb        <= '0;
            o_axi_awready <= 1'b0;
            o_axi_wready  <= 1'b0;
            o_axi_bvalid  <= 1'b0;
            o_axi_bid     <= '0;
            o_axi_bresp   <= RESP_OKAY;
        end else begin
            case (wstate)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_held   <= 1'b1;
                        o_axi_bid <= i_axi_awid;
                        w_word    <= i_axi_awaddr[MEM_AW+2:3];
                        w_err     <= out_of_range(i_axi_awaddr) || (i_axi_awlen != 8'd0);
                    end
                    if (w_hs && !w_first_held) begin
                        w_first_held <= 1'b1;
                        w_data       <= i_axi_wdata;
                        w_strb       <= i_axi_wstrb;
                    end
                    if (w_last_hs) w_held <= 1'b1;
                    o_axi_awready <= !(aw_held || aw_hs);
                    o_axi_wready  <= !(w_held || w_last_hs);
                    if ((aw_held || aw_hs) && (w_held || w_last_hs)) wstate <= W_ARB;
                end
                W_ARB: begin
                    if (w_gnt) begin
                        wstate       <= W_RESP;
                        o_axi_bvalid <= 1'b1;
                        o_axi_bresp  <= w_err ? RESP_SLVERR : RESP_OKAY;
                    end
                end
                W_RESP: begin
                    if (i_axi_bready) begin
                        wstate        <= W_IDLE;
                        o_axi_bvalid  <= 1'b0;
                        aw_held       <= 1'b0;
                        w_held        <= 1'b0;
                        w_first_held  <= 1'b0;
                        o_axi_awready <= 1'b1;
                        o_axi_wready  <= 1'b1;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rstate        <= R_IDLE;
            r_word        <= '0;
            r_err         <= 1'b0;
            r_use_ram     <= 1'b0;
            o_axi_arready <= 1'b0;
            o_axi_rvalid  <= 1'b0;
            o_axi_rlast   <= 1'b0;
            o_axi_rid     <= '0;
            o_axi_rresp   <= RESP_OKAY;
        end else begin
            case (rstate)
                R_IDLE: begin
                    o_axi_arready <= !ar_hs;
                    if (ar_hs) begin
                        rstate    <= R_ARB;
                        o_axi_rid <= i_axi_arid;
                        r_word    <= i_axi_araddr[MEM_AW+2:3];
                        r_err     <= out_of_range(i_axi_araddr) || (i_axi_arlen != 8'd0);
                    end
                end
                R_ARB: begin
                    if (r_gnt) begin
                        rstate       <= R_DATA;
                        o_axi_rvalid <= 1'b1;
                        o_axi_rlast  <= 1'b1;
                        o_axi_rresp  <= r_err ? RESP_SLVERR : RESP_OKAY;
                        r_use_ram    <= !r_err;
                    end
                end
                R_DATA: begin
                    if (i_axi_rready) begin
                        rstate        <= R_IDLE;
                        o_axi_rvalid  <= 1'b0;
                        o_axi_rlast   <= 1'b0;
                        r_use_ram     <= 1'b0;
                        o_axi_arready <= 1'b1;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    // The RAM's own read register holds the beat; errors and idle present zero
    assign o_axi_rdata = r_use_ram ? ram_q : '0;

    sram_1rw_be #(.DW(C_AXI_DATA_WIDTH), .AW(MEM_AW)) u_ram (
        .clk   (i_clk),
        .en    (ram_en),
        .we    (ram_we),
        .be    (w_strb),
        .addr  (ram_addr),
        .wdata (w_data),
        .rdata (ram_q)
    );

endmodule

// File: tb/tb_axi4_sram_slave.sv
// tb/tb_axi4_sram_slave.sv - self-checking bench for axi4_sram_slave
module tb_axi4_sram_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        awvalid = 1'b0, awready, awid = 1'b0;
    logic [25:0] awaddr = '0;
    logic [7:0]  awlen = '0;
    logic [2:0]  awsize = 3'd3;
    logic        wvalid = 1'b0, wready, wlast = 1'b0;
    logic [63:0] wdata = '0;
    logic [7:0]  wstrb = '0;
    logic        bvalid, bready = 1'b0, bid;
    logic [1:0]  bresp;
    logic        arvalid = 1'b0, arready, arid = 1'b0;
    logic [25:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic        rvalid, rready = 1'b0, rid, rlast;
    logic [63:0] rdata;
    logic [1:0]  rresp;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    axi4_sram_slave dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_axi_awvalid(awvalid), .o_axi_awready(awready), .i_axi_awid(awid),
        .i_axi_awaddr(awaddr), .i_axi_awlen(awlen), .i_axi_awsize(awsize),
        .i_axi_wvalid(wvalid), .o_axi_wready(wready), .i_axi_wdata(wdata),
        .i_axi_wstrb(wstrb), .i_axi_wlast(wlast),
        .o_axi_bvalid(bvalid), .i_axi_bready(bready), .o_axi_bid(bid), .o_axi_bresp(bresp),
        .i_axi_arvalid(arvalid), .o_axi_arready(arready), .i_axi_arid(arid),
        .i_axi_araddr(araddr), .i_axi_arlen(arlen),
        .o_axi_rvalid(rvalid), .i_axi_rready(rready), .o_axi_rid(rid),
        .o_axi_rdata(rdata), .o_axi_rresp(rresp), .o_axi_rlast(rlast)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [25:0] a, input logic id, input logic [63:0] d,
                             input logic [7:0] s, input logic [7:0] len, input int lead,
                             output logic [1:0] resp, output logic bid_o, output int lat);
        int beat, cyc, edges;
        bit aw_done, w_done, aw_hs, w_hs, got;
        beat = 0; cyc = 0; edges = 0; aw_done = 0; w_done = 0; got = 0;
        lat = -1; resp = 2'b11; bid_o = ~id;
        awaddr = a; awid = id; awlen = len; wdata = d; wstrb = s;
        wlast = (len == 0); wvalid = 1'b1; awvalid = 1'b0; bready = 1'b1;
        while (!(aw_done && w_done) && cyc < 40) begin
            if (!aw_done && cyc >= lead) awvalid = 1'b1;
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            tick();
            cyc++;
            if (aw_hs || w_hs) edges = 1;
            if (aw_hs) begin awvalid = 1'b0; aw_done = 1; end
            if (w_hs) begin
                if (beat == int'(len)) begin wvalid = 1'b0; w_done = 1; end
                else begin beat++; wdata = ~wdata; wlast = (beat == int'(len)); end
            end
        end
        awvalid = 1'b0; wvalid = 1'b0;
        check("aw_w_accepted", {63'd0, aw_done && w_done}, 64'd1);
        for (int i = 0; i < 20 && !got; i++) begin
            if (bvalid) begin got = 1; resp = bresp; bid_o = bid; lat = edges; end
            else begin tick(); edges++; end
        end
        check("b_seen", {63'd0, got}, 64'd1);
        tick();
    endtask

    task automatic axi_read(input logic [25:0] a, input logic id, input logic [7:0] len,
                            input int hold, output logic [63:0] d, output logic [1:0] resp,
                            output logic last, output logic rid_o, output int lat);
        int cyc, edges;
        bit done, hs, got, stable;
        cyc = 0; edges = 1; done = 0; got = 0; stable = 1;
        d = '1; resp = 2'b11; last = 1'b0; rid_o = ~id; lat = -1;
        araddr = a; arid = id; arlen = len; rready = 1'b0; arvalid = 1'b1;
        while (!done && cyc < 40) begin
            hs = arvalid && arready;
            tick();
            cyc++;
            if (hs) begin arvalid = 1'b0; done = 1; end
        end
        arvalid = 1'b0;
        check("ar_accepted", {63'd0, done}, 64'd1);
        for (int i = 0; i < 20 && !got; i++) begin
            if (rvalid) begin got = 1; d = rdata; resp = rresp; last = rlast; rid_o = rid; lat = edges; end
            else begin tick(); edges++; end
        end
        check("r_seen", {63'd0, got}, 64'd1);
        for (int h = 0; h < hold; h++) begin
            tick();
            if (!(rvalid === 1'b1 && rdata === d && rresp === resp && arready === 1'b0)) stable = 0;
        end
        if (hold > 0) check("r_hold_stable", {63'd0, stable}, 64'd1);
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    task automatic contend(input logic [25:0] a, input logic [63:0] d,
                           output int wlat, output int rlat, output logic [63:0] rd);
        awaddr = a; awid = 1'b0; awlen = '0; wdata = d; wstrb = 8'hFF; wlast = 1'b1;
        araddr = a; arid = 1'b1; arlen = '0; bready = 1'b1; rready = 1'b1;
        for (int i = 0; i < 10 && !(awready && wready && arready); i++) tick();
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        wlat = -1; rlat = -1; rd = '1;
        for (int e = 1; e <= 8; e++) begin
            if (bvalid && wlat < 0) wlat = e;
            if (rvalid && rlat < 0) begin rlat = e; rd = rdata; end
            tick();
        end
        rready = 1'b0;
    endtask

    typedef struct {
        bit          wr;
        logic [25:0] addr;
        logic        id;
        logic [63:0] data;
        logic [7:0]  strb;
        logic [7:0]  len;
        logic [1:0]  exp_resp;
        logic [63:0] exp_rdata;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];
    logic [63:0] ref_mem [8];

    logic [63:0] d_o, exp_d;
    logic [1:0]  resp_o, exp_r;
    logic        id_o, last_o, oor;
    int          lat, wlat, rlat, k, op;
    logic [25:0] a;
    logic [7:0]  len, s;
    logic [63:0] d;
    logic        id;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1, 26'h40,      1, 64'h1122334455667788, 8'hFF, 8'd0, 2'b00, 64'h0};
        vecs[1]  = '{0, 26'h40,      1, 64'h0,                8'h00, 8'd0, 2'b00, 64'h1122334455667788};
        vecs[2]  = '{1, 26'h48,      0, 64'h0102030405060708, 8'hFF, 8'd0, 2'b00, 64'h0};
        vecs[3]  = '{1, 26'h58,      1, 64'h0,                8'hFF, 8'd0, 2'b00, 64'h0};
        vecs[4]  = '{1, 26'h58,      0, 64'hFFFFFFFFFFFFFFFF, 8'h00, 8'd0, 2'b00, 64'h0};
        vecs[5]  = '{0, 26'h58,      0, 64'h0,                8'h00, 8'd0, 2'b00, 64'h0};
        vecs[6]  = '{1, 26'h5B,      1, 64'hDEADBEEFCAFEF00D, 8'hF0, 8'd0, 2'b00, 64'h0};
        vecs[7]  = '{0, 26'h58,      1, 64'h0,                8'h00, 8'd0, 2'b00, 64'hDEADBEEF00000000};
        vecs[8]  = '{0, 26'h2000,    1, 64'h0,                8'h00, 8'd0, 2'b10, 64'h0};
        vecs[9]  = '{1, 26'h2040,    0, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 8'd0, 2'b10, 64'h0};
        vecs[10] = '{0, 26'h40,      0, 64'h0,                8'h00, 8'd0, 2'b00, 64'h1122334455667788};
        vecs[11] = '{1, 26'h60,      1, 64'h5555555555555555, 8'hFF, 8'd0, 2'b00, 64'h0};
        vecs[12] = '{1, 26'h60,      0, 64'h0,                8'hFF, 8'd3, 2'b10, 64'h0};
        vecs[13] = '{0, 26'h60,      1, 64'h0,                8'h00, 8'd0, 2'b00, 64'h5555555555555555};
        vecs[14] = '{1, 26'h1FF8,    1, 64'h0123456789ABCDEF, 8'hFF, 8'd0, 2'b00, 64'h0};
        vecs[15] = '{0, 26'h1FF8,    0, 64'h0,                8'h00, 8'd0, 2'b00, 64'h0123456789ABCDEF};
        vecs[16] = '{0, 26'h1FF8,    1, 64'h0,                8'h00, 8'd1, 2'b10, 64'h0};
        vecs[17] = '{0, 26'h2000000, 0, 64'h0,                8'h00, 8'd0, 2'b10, 64'h0};

        repeat (3) tick();
        check("reset_outputs",
              {32'd0, awready, wready, bvalid, bresp, bid, arready, rvalid, rresp, rid, rlast, 19'd0},
              64'd0);
        check("reset_rdata", rdata, 64'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        for (int v = 0; v < NV; v++) begin
            if (vecs[v].wr) begin
                axi_write(vecs[v].addr, vecs[v].id, vecs[v].data, vecs[v].strb, vecs[v].len, 0,
                          resp_o, id_o, lat);
                check($sformatf("vec%0d_bresp", v), {62'd0, resp_o}, {62'd0, vecs[v].exp_resp});
                check($sformatf("vec%0d_bid", v), {63'd0, id_o}, {63'd0, vecs[v].id});
                check($sformatf("vec%0d_blat", v), lat, 2);
            end else begin
                axi_read(vecs[v].addr, vecs[v].id, vecs[v].len, 0, d_o, resp_o, last_o, id_o, lat);
                check($sformatf("vec%0d_rresp", v), {62'd0, resp_o}, {62'd0, vecs[v].exp_resp});
                check($sformatf("vec%0d_rdata", v), d_o, vecs[v].exp_rdata);
                check($sformatf("vec%0d_rlast", v), {63'd0, last_o}, 64'd1);
                check($sformatf("vec%0d_rid", v), {63'd0, id_o}, {63'd0, vecs[v].id});
                check($sformatf("vec%0d_rlat", v), lat, 2);
            end
        end

        axi_write(26'h48, 1'b0, 64'h00000000AAAAAAAA, 8'h0F, 8'd0, 3, resp_o, id_o, lat);
        check("w_lead_bresp", {62'd0, resp_o}, 64'd0);
        check("w_lead_blat", lat, 2);
        axi_read(26'h48, 1'b1, 8'd0, 0, d_o, resp_o, last_o, id_o, lat);
        check("w_lead_rdata", d_o, 64'h01020304AAAAAAAA);

        axi_read(26'h40, 1'b0, 8'd0, 5, d_o, resp_o, last_o, id_o, lat);
        check("hold_rdata", d_o, 64'h1122334455667788);
        check("hold_rvalid_after", {63'd0, rvalid}, 64'd0);

        for (int i = 0; i < 8; i++) begin
            ref_mem[i] = {$urandom, $urandom};
            axi_write(26'h100 + 26'(i * 8), 1'b0, ref_mem[i], 8'hFF, 8'd0, 0, resp_o, id_o, lat);
            check("rnd_init_bresp", {62'd0, resp_o}, 64'd0);
        end
        for (int n = 0; n < 80; n++) begin
            k   = $urandom_range(0, 7);
            oor = ($urandom_range(0, 7) == 0);
            a   = 26'h100 + 26'(k * 8) + 26'($urandom_range(0, 7));
            if (oor) a = a | (26'd1 << $urandom_range(13, 25));
            len = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 3)) : 8'd0;
            id  = 1'($urandom);
            op  = $urandom_range(0, 1);
            exp_r = (oor || len != 0) ? 2'b10 : 2'b00;
            if (op == 1) begin
                d = {$urandom, $urandom};
                s = 8'($urandom);
                axi_write(a, id, d, s, len, $urandom_range(0, 2), resp_o, id_o, lat);
                if (exp_r == 2'b00) begin
                    for (int b = 0; b < 8; b++)
                        if (s[b]) ref_mem[k][8*b +: 8] = d[8*b +: 8];
                end
                check("rnd_bresp", {62'd0, resp_o}, {62'd0, exp_r});
                check("rnd_bid", {63'd0, id_o}, {63'd0, id});
            end else begin
                exp_d = (exp_r == 2'b00) ? ref_mem[k] : 64'd0;
                axi_read(a, id, len, $urandom_range(0, 2), d_o, resp_o, last_o, id_o, lat);
                check("rnd_rresp", {62'd0, resp_o}, {62'd0, exp_r});
                check("rnd_rdata", d_o, exp_d);
                check("rnd_rid", {63'd0, id_o}, {63'd0, id});
                check("rnd_rlat", lat, 2);
            end
        end

        araddr = 26'h40; arid = 1'b1; arlen = '0; rready = 1'b0;
        for (int i = 0; i < 10 && !arready; i++) tick();
        arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        for (int i = 0; i < 10 && !rvalid; i++) tick();
        check("rst_pre_rvalid", {63'd0, rvalid}, 64'd1);
        rst_n = 1'b0;
        #2;
        check("rst_rvalid_low", {63'd0, rvalid}, 64'd0);
        check("rst_rdata_zero", rdata, 64'd0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("rst_after_idle", {61'd0, rvalid, arready, awready}, 64'd3);

        contend(26'h50, 64'hA5A5A5A5F0F0F0F0, wlat, rlat, d_o);
        check("cont1_wlat", wlat, 2);
        check("cont1_rlat", rlat, 3);
        check("cont1_rdata", d_o, 64'hA5A5A5A5F0F0F0F0);
        contend(26'h50, 64'h0F0F0F0F12345678, wlat, rlat, d_o);
        check("cont2_rlat", rlat, 2);
        check("cont2_wlat", wlat, 3);
        check("cont2_rdata", d_o, 64'hA5A5A5A5F0F0F0F0);
        axi_read(26'h50, 1'b0, 8'd0, 0, d_o, resp_o, last_o, id_o, lat);
        check("cont2_readback", d_o, 64'h0F0F0F0F12345678);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
